// File: rtl/dp_pkg.sv
// Shared widths and bus-mux select codes for the single-bus register datapath.
package dp_pkg;

    localparam int DATA_W  = 32;
    localparam int NUM_GPR = 16;
    localparam int SEL_W   = 5;

    localparam logic [SEL_W-1:0] SEL_R0     = 5'd0;
    localparam logic [SEL_W-1:0] SEL_R15    = 5'd15;
    localparam logic [SEL_W-1:0] SEL_HI     = 5'd16;
    localparam logic [SEL_W-1:0] SEL_LO     = 5'd17;
    localparam logic [SEL_W-1:0] SEL_ZHI    = 5'd18;
    localparam logic [SEL_W-1:0] SEL_ZLO    = 5'd19;
    localparam logic [SEL_W-1:0] SEL_PC     = 5'd20;
    localparam logic [SEL_W-1:0] SEL_MDR    = 5'd21;
    localparam logic [SEL_W-1:0] SEL_INPORT = 5'd22;
    localparam logic [SEL_W-1:0] SEL_C      = 5'd23;

endpackage

// File: rtl/datapath_bus_core_if.sv
// Control-unit/ALU side signal bundle of the datapath: strobes, load enables, data in, bus out.
interface datapath_bus_core_if;
    import dp_pkg::*;

    logic [NUM_GPR-1:0]  r_in;
    logic [NUM_GPR-1:0]  r_out;
    logic                pc_in, ir_in, y_in, hi_in, lo_in, zhi_in, zlo_in, mdr_in;
    logic                pc_out, hi_out, lo_out, zhi_out, zlo_out, mdr_out, inport_out, c_out;
    logic                read;
    logic [DATA_W-1:0]   mdatain;
    logic [DATA_W-1:0]   inport_data;
    logic [DATA_W-1:0]   c_sign_ext;
    logic [2*DATA_W-1:0] z_data;
    logic [DATA_W-1:0]   bus;
    logic [DATA_W-1:0]   y_q;
    logic [DATA_W-1:0]   ir_q;
    logic [SEL_W-1:0]    sel;
    logic                sel_valid;

    modport master (
        output r_in, r_out,
        output pc_in, ir_in, y_in, hi_in, lo_in, zhi_in, zlo_in, mdr_in,
        output pc_out, hi_out, lo_out, zhi_out, zlo_out, mdr_out, inport_out, c_out,
        output read, mdatain, inport_data, c_sign_ext, z_data,
        input  bus, y_q, ir_q, sel, sel_valid
    );

    modport slave (
        input  r_in, r_out,
        input  pc_in, ir_in, y_in, hi_in, lo_in, zhi_in, zlo_in, mdr_in,
        input  pc_out, hi_out, lo_out, zhi_out, zlo_out, mdr_out, inport_out, c_out,
        input  read, mdatain, inport_data, c_sign_ext, z_data,
        output bus, y_q, ir_q, sel, sel_valid
    );

endinterface

// File: rtl/dp_reg32.sv
// 32-bit load-enable register with asynchronous active-low clear.
module dp_reg32
    import dp_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] q_d;

    assign q_d = en_i ? d_i : q_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) q_q <= '0;
        else      q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/datapath_bus_core.sv
// Single-bus register datapath: GPRs + special registers, priority-encoded bus mux.
// Optional R0_ZERO_EN: R0 hardwired to zero (loads ignored, reads as 0).
module datapath_bus_core
    import dp_pkg::*;
(
    input  logic               clk,
    input  logic               clr,
    datapath_bus_core_if.slave dp
);

    logic [DATA_W-1:0] gpr_q [NUM_GPR];
    logic [DATA_W-1:0] pc_q, ir_q, y_q, hi_q, lo_q, zhi_q, zlo_q, mdr_q;
    logic [DATA_W-1:0] mdr_d;
    logic [DATA_W-1:0] bus_val;
    logic [31:0]       enc_vec;
    logic [SEL_W-1:0]  sel_c;
    logic              sel_valid_c;

`ifdef R0_ZERO_EN
    localparam int GPR_FIRST = 1;
    logic unused_r0_in;
    assign unused_r0_in = dp.r_in[0];
    assign gpr_q[0]     = '0;
`else
    localparam int GPR_FIRST = 0;
`endif

    for (genvar i = GPR_FIRST; i < NUM_GPR; i++) begin : g_gpr
        dp_reg32 u_gpr (.clk(clk), .clr(clr), .en_i(dp.r_in[i]), .d_i(bus_val), .q_o(gpr_q[i]));
    end

    dp_reg32 u_pc  (.clk(clk), .clr(clr), .en_i(dp.pc_in),  .d_i(bus_val), .q_o(pc_q));
    dp_reg32 u_ir  (.clk(clk), .clr(clr), .en_i(dp.ir_in),  .d_i(bus_val), .q_o(ir_q));
    dp_reg32 u_y   (.clk(clk), .clr(clr), .en_i(dp.y_in),   .d_i(bus_val), .q_o(y_q));
    dp_reg32 u_hi  (.clk(clk), .clr(clr), .en_i(dp.hi_in),  .d_i(bus_val), .q_o(hi_q));
    dp_reg32 u_lo  (.clk(clk), .clr(clr), .en_i(dp.lo_in),  .d_i(bus_val), .q_o(lo_q));
    dp_reg32 u_zhi (.clk(clk), .clr(clr), .en_i(dp.zhi_in), .d_i(dp.z_data[2*DATA_W-1:DATA_W]), .q_o(zhi_q));
    dp_reg32 u_zlo (.clk(clk), .clr(clr), .en_i(dp.zlo_in), .d_i(dp.z_data[DATA_W-1:0]), .q_o(zlo_q));

    assign mdr_d = dp.read ? dp.mdatain : bus_val;
    dp_reg32 u_mdr (.clk(clk), .clr(clr), .en_i(dp.mdr_in), .d_i(mdr_d), .q_o(mdr_q));

    // Encoder bit order fixes bus priority: later sources override earlier ones.
    assign enc_vec = {8'h00, dp.c_out, dp.inport_out, dp.mdr_out, dp.pc_out,
                      dp.zlo_out, dp.zhi_out, dp.lo_out, dp.hi_out, dp.r_out};

    always_comb begin
        sel_c = '0;
        for (int i = 0; i < 32; i++) begin
            if (enc_vec[i]) sel_c = SEL_W'(i);
        end
    end

    assign sel_valid_c = |enc_vec;

    always_comb begin
        bus_val = '0;
        if (sel_valid_c) begin
            if (sel_c <= SEL_R15) begin
                bus_val = gpr_q[sel_c[3:0]];
            end else begin
                case (sel_c)
                    SEL_HI:     bus_val = hi_q;
                    SEL_LO:     bus_val = lo_q;
                    SEL_ZHI:    bus_val = zhi_q;
                    SEL_ZLO:    bus_val = zlo_q;
                    SEL_PC:     bus_val = pc_q;
                    SEL_MDR:    bus_val = mdr_q;
                    SEL_INPORT: bus_val = dp.inport_data;
                    SEL_C:      bus_val = dp.c_sign_ext;
                    default:    bus_val = '0;
                endcase
            end
        end
    end

    assign dp.bus       = bus_val;
    assign dp.sel       = sel_c;
    assign dp.sel_valid = sel_valid_c;
    assign dp.y_q       = y_q;
    assign dp.ir_q      = ir_q;

endmodule

// File: tb/tb_datapath_bus_core.sv
// Randomized self-checking bench for datapath_bus_core against a behavioural register-file model.
module tb_datapath_bus_core;
    import dp_pkg::*;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    datapath_bus_core_if bus_if ();

    datapath_bus_core u_dut (
        .clk (clk),
        .clr (clr),
        .dp  (bus_if.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m_gpr [16];
    logic [31:0] m_pc, m_ir, m_y, m_hi, m_lo, m_zhi, m_zlo, m_mdr;

`ifdef R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_gpr[i] = '0;
        m_pc = '0; m_ir = '0; m_y = '0; m_hi = '0; m_lo = '0; m_zhi = '0; m_zlo = '0; m_mdr = '0;
    endtask

    task automatic clear_ctrl();
        bus_if.r_in = '0;  bus_if.r_out = '0;
        bus_if.pc_in = 0;  bus_if.ir_in = 0;  bus_if.y_in = 0;   bus_if.hi_in = 0;
        bus_if.lo_in = 0;  bus_if.zhi_in = 0; bus_if.zlo_in = 0; bus_if.mdr_in = 0;
        bus_if.pc_out = 0; bus_if.hi_out = 0; bus_if.lo_out = 0; bus_if.zhi_out = 0;
        bus_if.zlo_out = 0; bus_if.mdr_out = 0; bus_if.inport_out = 0; bus_if.c_out = 0;
        bus_if.read = 0;
    endtask

    // Source number s: 0..15 GPR, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 inport, 23 C
    task automatic set_src(input int s);
        if (s < 16) bus_if.r_out[s] = 1'b1;
        else case (s)
            16: bus_if.hi_out = 1;  17: bus_if.lo_out = 1;  18: bus_if.zhi_out = 1;
            19: bus_if.zlo_out = 1; 20: bus_if.pc_out = 1;  21: bus_if.mdr_out = 1;
            22: bus_if.inport_out = 1; default: bus_if.c_out = 1;
        endcase
    endtask

    function automatic int exp_src();
        if (bus_if.c_out)      return 23;
        if (bus_if.inport_out) return 22;
        if (bus_if.mdr_out)    return 21;
        if (bus_if.pc_out)     return 20;
        if (bus_if.zlo_out)    return 19;
        if (bus_if.zhi_out)    return 18;
        if (bus_if.lo_out)     return 17;
        if (bus_if.hi_out)     return 16;
        for (int i = 15; i >= 0; i--) if (bus_if.r_out[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] src_val(input int s);
        if (s < 0) return 32'h0;
        if (s < 16) return (s == 0 && R0_ZERO) ? 32'h0 : m_gpr[s];
        case (s)
            16: return m_hi;  17: return m_lo;  18: return m_zhi; 19: return m_zlo;
            20: return m_pc;  21: return m_mdr; 22: return bus_if.inport_data;
            default: return bus_if.c_sign_ext;
        endcase
    endfunction

    // Check combinational outputs against the model, then clock one edge and update the model.
    task automatic step(input string tag);
        int s;
        logic [31:0] eb;
        #1;
        s  = exp_src();
        eb = src_val(s);
        chk({tag, ".bus"}, 64'(bus_if.bus), 64'(eb));
        chk({tag, ".sel"}, 64'(bus_if.sel), (s < 0) ? 64'd0 : 64'(s));
        chk({tag, ".vld"}, 64'(bus_if.sel_valid), (s < 0) ? 64'd0 : 64'd1);
        chk({tag, ".y"},   64'(bus_if.y_q),  64'(m_y));
        chk({tag, ".ir"},  64'(bus_if.ir_q), 64'(m_ir));
        @(posedge clk);
        if (clr) begin
            for (int i = 0; i < 16; i++)
                if (bus_if.r_in[i] && !(i == 0 && R0_ZERO)) m_gpr[i] = eb;
            if (bus_if.pc_in)  m_pc  = eb;
            if (bus_if.ir_in)  m_ir  = eb;
            if (bus_if.y_in)   m_y   = eb;
            if (bus_if.hi_in)  m_hi  = eb;
            if (bus_if.lo_in)  m_lo  = eb;
            if (bus_if.zhi_in) m_zhi = bus_if.z_data[63:32];
            if (bus_if.zlo_in) m_zlo = bus_if.z_data[31:0];
            if (bus_if.mdr_in) m_mdr = bus_if.read ? bus_if.mdatain : eb;
        end
        #1;
    endtask

    // Mid-cycle clear: every register source must read 0 while clr is low and after release.
    task automatic do_reset();
        #2;
        clr = 1'b0;
        model_clear();
        for (int s = 0; s < 22; s++) begin
            clear_ctrl();
            set_src(s);
            #1;
            chk("rst_low.bus", 64'(bus_if.bus), 64'd0);
        end
        clear_ctrl();
        #1;
        chk("rst_low.vld", 64'(bus_if.sel_valid), 64'd0);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        for (int s = 0; s < 22; s++) begin
            clear_ctrl();
            set_src(s);
            step("rst_read");
        end
        clear_ctrl();
    endtask

    initial begin
        clr = 1'b0;
        clear_ctrl();
        bus_if.mdatain = '0; bus_if.inport_data = '0; bus_if.c_sign_ext = '0; bus_if.z_data = '0;
        model_clear();
        #2;
        chk("init.bus", 64'(bus_if.bus), 64'd0);
        chk("init.vld", 64'(bus_if.sel_valid), 64'd0);
        chk("init.sel", 64'(bus_if.sel), 64'd0);
        #10 clr = 1'b1;
        @(posedge clk);
        #1;

        // MDR memory load
        bus_if.mdatain = 32'h0000_0022; bus_if.read = 1; bus_if.mdr_in = 1;
        step("mdr_load");
        clear_ctrl(); bus_if.mdatain = '0; bus_if.mdr_out = 1;
        #1;
        chk("mdr_out.bus", 64'(bus_if.bus), 64'h22);
        chk("mdr_out.sel", 64'(bus_if.sel), 64'd21);
        step("mdr_out");

        // MDR -> R2 transfer
        bus_if.mdr_out = 1; bus_if.r_in[2] = 1;
        step("xfer_r2");
        clear_ctrl(); bus_if.r_out[2] = 1;
        #1;
        chk("r2_out.bus", 64'(bus_if.bus), 64'h22);
        chk("r2_out.sel", 64'(bus_if.sel), 64'd2);
        step("r2_out");

        // Priority
        clear_ctrl(); bus_if.inport_data = 32'h1234_5678; bus_if.inport_out = 1; bus_if.pc_in = 1;
        step("pc_load");
        clear_ctrl(); bus_if.r_out[3] = 1; bus_if.pc_out = 1;
        #1;
        chk("prio_pc.sel", 64'(bus_if.sel), 64'd20);
        chk("prio_pc.bus", 64'(bus_if.bus), 64'h1234_5678);
        bus_if.c_sign_ext = 32'hFFFF_FF80; bus_if.c_out = 1;
        #1;
        chk("prio_c.sel", 64'(bus_if.sel), 64'd23);
        chk("prio_c.bus", 64'(bus_if.bus), 64'hFFFF_FF80);
        step("prio");

        // Z path
        clear_ctrl(); bus_if.z_data = 64'h0000_0001_8000_0000; bus_if.zhi_in = 1; bus_if.zlo_in = 1;
        step("z_load");
        clear_ctrl(); bus_if.z_data = '0; bus_if.zhi_out = 1;
        #1;
        chk("zhi.bus", 64'(bus_if.bus), 64'h1);
        clear_ctrl(); bus_if.zlo_out = 1;
        #1;
        chk("zlo.bus", 64'(bus_if.bus), 64'h8000_0000);
        step("zlo");

        // R0 write/read
        clear_ctrl(); bus_if.inport_data = 32'h55; bus_if.inport_out = 1; bus_if.r_in[0] = 1;
        step("r0_load");
        clear_ctrl(); bus_if.r_out[0] = 1;
        #1;
        chk("r0.bus", 64'(bus_if.bus), R0_ZERO ? 64'h0 : 64'h55);
        step("r0_out");

        // Self-transfer
        clear_ctrl(); bus_if.r_out[2] = 1; bus_if.r_in[2] = 1;
        step("self_xfer");
        clear_ctrl(); bus_if.r_out[2] = 1;
        #1;
        chk("self.bus", 64'(bus_if.bus), 64'h22);
        step("self_out");

        // Randomized traffic with a mid-run clear
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            clear_ctrl();
            bus_if.r_in  = 16'($urandom & $urandom);
            bus_if.r_out = 16'($urandom & $urandom & $urandom);
            bus_if.pc_in = ($urandom_range(0, 3) == 0); bus_if.ir_in  = ($urandom_range(0, 3) == 0);
            bus_if.y_in  = ($urandom_range(0, 3) == 0); bus_if.hi_in  = ($urandom_range(0, 3) == 0);
            bus_if.lo_in = ($urandom_range(0, 3) == 0); bus_if.zhi_in = ($urandom_range(0, 3) == 0);
            bus_if.zlo_in = ($urandom_range(0, 3) == 0); bus_if.mdr_in = ($urandom_range(0, 3) == 0);
            bus_if.pc_out = ($urandom_range(0, 5) == 0); bus_if.hi_out = ($urandom_range(0, 5) == 0);
            bus_if.lo_out = ($urandom_range(0, 5) == 0); bus_if.zhi_out = ($urandom_range(0, 5) == 0);
            bus_if.zlo_out = ($urandom_range(0, 5) == 0); bus_if.mdr_out = ($urandom_range(0, 5) == 0);
            bus_if.inport_out = ($urandom_range(0, 7) == 0); bus_if.c_out = ($urandom_range(0, 7) == 0);
            bus_if.read = $urandom_range(0, 1);
            bus_if.mdatain = $urandom; bus_if.inport_data = $urandom; bus_if.c_sign_ext = $urandom;
            bus_if.z_data = {$urandom, $urandom};
            step("rnd");
        end

        clear_ctrl();
        #1;
        chk("idle.vld", 64'(bus_if.sel_valid), 64'd0);
        chk("idle.bus", 64'(bus_if.bus), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_bus_core.md
Name: datapath_bus_core

Overview:
Single-bus register datapath core. It holds the general registers R0-R15 and the special registers PC, IR, Y, HI, LO, ZHI, ZLO and MDR, all sharing one 32-bit bus. A 32-to-5 priority encoder turns the one-hot "out" strobes into a bus-mux select, and the selected source drives the bus. It sits between the control unit, which drives the strobes, and the ALU, which takes the bus and Y and returns the Z data.

Parameters:
- DATA_W, 32, width of the bus and of every register (fixed; other values are not supported).
- NUM_GPR, 16, number of general registers (fixed).

Ports:
- clk  in  1  system clock; all registers update on its rising edge.
- clr  in  1  asynchronous active-low reset.
- r_in  in  16  per-GPR load enable; bit i loads Ri.
- r_out  in  16  per-GPR bus-drive strobe; bit i drives Ri onto the bus.
- pc_in, ir_in, y_in, hi_in, lo_in, zhi_in, zlo_in, mdr_in  in  1 each  load enables.
- pc_out, hi_out, lo_out, zhi_out, zlo_out, mdr_out, inport_out, c_out  in  1 each  bus-drive strobes.
- read  in  1  MDR input select: 1 = mdatain, 0 = bus.
- mdatain  in  32  memory read data.
- inport_data  in  32  input-port value.
- c_sign_ext  in  32  sign-extended immediate from IR decode.
- z_data  in  64  ALU result; [63:32] goes to ZHI, [31:0] goes to ZLO.
- bus  out  32  current bus value (combinational).
- y_q  out  32  Y register contents, to the ALU.
- ir_q  out  32  IR register contents.
- sel  out  5  encoder select code (combinational).
- sel_valid  out  1  high when at least one out strobe is asserted.

Behaviour:
- Reset: clr low clears every register to 0 immediately, independent of clk, and holds them at 0 while low. Loads resume on the first rising edge after clr goes high.
- Register load: on the rising edge of clk, a register whose enable is 1 captures its D input; otherwise it holds.
  - GPRs, PC, IR, Y, HI and LO: D = bus.
  - ZHI: D = z_data[63:32]. ZLO: D = z_data[31:0].
  - MDR: D = read ? mdatain : bus.
- Encoder input vector, bit index to source:
  - bits 0-15: r_out[0..15]
  - 16 hi_out, 17 lo_out, 18 zhi_out, 19 zlo_out
  - 20 pc_out, 21 mdr_out, 22 inport_out, 23 c_out
  - bits 24-31 tied 0
- Encoder priority: the highest set bit wins, and sel is its index. sel_valid = OR of all input bits.
- No strobe asserted: sel = 0, sel_valid = 0.
- Bus mux: bus = source selected by sel when sel_valid = 1, else 32'h0.
  - sel 22 selects inport_data; sel 23 selects c_sign_ext.
  - Codes 24-31 cannot occur and map to 0.
- Latency:
  - bus and sel: combinational from the strobes and register outputs, 0 cycles.
  - Register writes: visible on bus the cycle after the load edge.
- Self-transfer: a register that drives the bus and loads in the same cycle captures its own old value (no-op).
- Simultaneous loads: multiple in-enables in one cycle all capture the same bus value.
- Bus width: no masking or extension on the bus; all sources are 32 bits.

Optional Feature:
- Macro R0_ZERO_EN.
- Defined: R0 is hardwired to zero. r_in[0] is ignored, and selecting R0 (r_out[0]) drives 32'h0 onto the bus.
- Undefined: R0 is an ordinary read/write register like R1-R15.

Decomposition:
- Shared package dp_pkg:
  - DATA_W.
  - localparams for the select codes: SEL_R0..SEL_R15 = 0..15, SEL_HI = 16, SEL_LO = 17, SEL_ZHI = 18, SEL_ZLO = 19, SEL_PC = 20, SEL_MDR = 21, SEL_INPORT = 22, SEL_C = 23.
- Sub-module dp_reg32: a 32-bit register with enable and async active-low clear, instantiated for every register.
- MDR input mux, encoder and bus mux stay inline in datapath_bus_core.

Test Plan:
- Reset: pulse clr low mid-cycle -> every register reads 0 on bus via each out strobe; with no strobe, sel_valid = 0 and bus = 0.
- MDR memory load: mdatain = 32'h0000_0022, read = 1, mdr_in = 1 for one edge; then mdr_out = 1 -> bus = 32'h22, sel = 21.
- Bus transfer: MDR = 32'h22, mdr_out = 1, r_in[2] = 1 for one edge; then r_out[2] = 1 -> bus = 32'h22, sel = 2.
- Priority: r_out[3] = 1 and pc_out = 1 together -> sel = 20 and bus = PC value; c_out = 1 added -> sel = 23 and bus = c_sign_ext.
- Z path: z_data = 64'h0000_0001_8000_0000, zhi_in = zlo_in = 1 for one edge -> zhi_out gives 32'h1; zlo_out gives 32'h8000_0000.
- R0_ZERO_EN defined: bus = 32'h55, r_in[0] = 1; then r_out[0] = 1 -> bus = 0. Undefined: the same sequence gives bus = 32'h55.
